// File: rtl/cdb_arbiter_pkg.sv
// Shared defaults and helpers for the CDB arbiter.
// Widths here seed the interface and top parameters.
package cdb_arbiter_pkg;

  localparam int NUM_SRC_D = 4;
  localparam int DATA_W_D  = 32;
  localparam int LABEL_W_D = 4;
  localparam int AGE_MAX_D = 3;
  localparam int AGE_W     = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SRC_W_D = idx_w(NUM_SRC_D);

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit request bundle and CDB broadcast.
// The master side is the FU/consumer; the slave side is the arbiter.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_D,
  parameter int DATA_W  = DATA_W_D,
  parameter int LABEL_W = LABEL_W_D,
  parameter int SRC_W   = idx_w(NUM_SRC)
);

  logic [NUM_SRC-1:0]         require;
  logic [NUM_SRC*LABEL_W-1:0] label_in;
  logic [NUM_SRC*DATA_W-1:0]  data_in;
  logic                       stall;
  logic [NUM_SRC-1:0]         requireAC;
  logic                       cdb_valid;
  logic [LABEL_W-1:0]         cdb_label;
  logic [DATA_W-1:0]          cdb_data;
  logic [SRC_W-1:0]           cdb_src;

  modport master (
    output require, label_in, data_in, stall,
    input  requireAC, cdb_valid, cdb_label,
    input  cdb_data, cdb_src
  );

  modport slave (
    input  require, label_in, data_in, stall,
    output requireAC, cdb_valid, cdb_label,
    output cdb_data, cdb_src
  );

endinterface

// File: rtl/cdb_arbiter_prio_pick.sv
// Lowest-index-first one-hot picker.
// Emits the winning one-hot vector and its binary index.
module cdb_prio_pick
  import cdb_arbiter_pkg::*;
#(
  parameter int N  = NUM_SRC_D,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Fixed-priority CDB arbiter with per-source aging.
// Grant is combinational; the winner is broadcast one cycle later.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_D,
  parameter int DATA_W  = DATA_W_D,
  parameter int LABEL_W = LABEL_W_D,
  parameter int AGE_MAX = AGE_MAX_D,
  parameter int SRC_W   = idx_w(NUM_SRC)
) (
  input logic        clk,
  input logic        RST,
  cdb_arbiter_if.slave bus
);

  localparam logic [AGE_W-1:0] AGE_TOP = AGE_W'(AGE_MAX);

  logic [NUM_SRC-1:0][AGE_W-1:0] age_q, age_d;

  logic               valid_q, valid_d;
  logic [LABEL_W-1:0] label_q, label_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [SRC_W-1:0]   src_q, src_d;

  logic [NUM_SRC-1:0] starved;
  logic [NUM_SRC-1:0] s_gnt, r_gnt, gnt;
  logic [SRC_W-1:0]   s_idx, r_idx, g_idx;
  logic               block;

  always_comb begin
    starved = '0;
    for (int i = 0; i < NUM_SRC; i++)
      starved[i] = bus.require[i] && (age_q[i] == AGE_TOP);
  end

  cdb_prio_pick #(.N(NUM_SRC), .IW(SRC_W)) u_pick_starved (
    .req_i (starved),
    .gnt_o (s_gnt),
    .idx_o (s_idx)
  );

  cdb_prio_pick #(.N(NUM_SRC), .IW(SRC_W)) u_pick_req (
    .req_i (bus.require),
    .gnt_o (r_gnt),
    .idx_o (r_idx)
  );

  // Aged requesters override fixed priority; stall/reset mask all grants.
  assign block = bus.stall || RST;
  assign gnt   = block ? '0 : ((|starved) ? s_gnt : r_gnt);
  assign g_idx = (|starved) ? s_idx : r_idx;

  always_comb begin
    age_d = age_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.stall)
        age_d[i] = age_q[i];
      else if (bus.require[i] && !gnt[i])
        age_d[i] = (age_q[i] == AGE_TOP) ? age_q[i] : age_q[i] + 1'b1;
      else
        age_d[i] = '0;
    end
  end

  always_comb begin
    valid_d = |gnt;
    label_d = label_q;
    data_d  = data_q;
    src_d   = src_q;
    if (|gnt) begin
      label_d = bus.label_in[g_idx*LABEL_W +: LABEL_W];
      data_d  = bus.data_in[g_idx*DATA_W +: DATA_W];
      src_d   = g_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      age_q   <= '0;
      valid_q <= 1'b0;
      label_q <= '0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      age_q   <= age_d;
      valid_q <= valid_d;
      label_q <= label_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign bus.requireAC = gnt;
  assign bus.cdb_valid = valid_q;
  assign bus.cdb_label = label_q;
  assign bus.cdb_data  = data_q;
  assign bus.cdb_src   = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter.
// Inputs change on negedge; outputs sampled mid-phase.
module tb_cdb_arbiter;

  logic clk;
  logic RST;
  int   checks;
  int   errors;

  cdb_arbiter_if #(
    .NUM_SRC(4), .DATA_W(32), .LABEL_W(4), .SRC_W(2)
  ) bus ();

  cdb_arbiter #(
    .NUM_SRC(4), .DATA_W(32), .LABEL_W(4),
    .AGE_MAX(3), .SRC_W(2)
  ) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_src(input int i, input logic [3:0] l,
                         input logic [31:0] d);
    bus.label_in[i*4 +: 4]   = l;
    bus.data_in[i*32 +: 32]  = d;
  endtask

  task automatic test_reset();
    RST         = 1'b1;
    bus.require = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.requireAC !== 4'b0000) begin
        errors++;
        $display("FAIL reset_gnt: got %b want 0000", bus.requireAC);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bus.cdb_valid !== 1'b0 || bus.cdb_label !== 4'h0 ||
        bus.cdb_data !== 32'h0 || bus.cdb_src !== 2'd0) begin
      errors++;
      $display("FAIL reset_cdb: got v=%b l=%h d=%h s=%0d want 0/0/0/0",
               bus.cdb_valid, bus.cdb_label, bus.cdb_data, bus.cdb_src);
    end
    @(negedge clk);
    RST         = 1'b0;
    bus.require = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_src(2, 4'h9, 32'h0000_0015);
    bus.require = 4'b0100;
    #1;
    checks++;
    if (bus.requireAC !== 4'b0100) begin
      errors++;
      $display("FAIL single_gnt: got %b want 0100", bus.requireAC);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.cdb_valid !== 1'b1 || bus.cdb_label !== 4'h9 ||
        bus.cdb_data !== 32'h15 || bus.cdb_src !== 2'd2) begin
      errors++;
      $display("FAIL single_cdb: got v=%b l=%h d=%h s=%0d want 1/9/15/2",
               bus.cdb_valid, bus.cdb_label, bus.cdb_data, bus.cdb_src);
    end
    @(negedge clk);
    bus.require = 4'b0000;
    #1;
    checks++;
    if (bus.requireAC !== 4'b0000) begin
      errors++;
      $display("FAIL single_idle_gnt: got %b want 0000", bus.requireAC);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.cdb_valid !== 1'b0 || bus.cdb_data !== 32'h15) begin
      errors++;
      $display("FAIL single_hold: got v=%b d=%h want 0/15",
               bus.cdb_valid, bus.cdb_data);
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    set_src(1, 4'h5, 32'hA5A5_0001);
    set_src(3, 4'hC, 32'h3333_3333);
    bus.require = 4'b1010;
    #1;
    checks++;
    if (bus.requireAC !== 4'b0010) begin
      errors++;
      $display("FAIL prio_gnt: got %b want 0010", bus.requireAC);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.cdb_label !== 4'h5 || bus.cdb_data !== 32'hA5A5_0001 ||
        bus.cdb_src !== 2'd1) begin
      errors++;
      $display("FAIL prio_cdb: got l=%h d=%h s=%0d want 5/a5a50001/1",
               bus.cdb_label, bus.cdb_data, bus.cdb_src);
    end
    @(negedge clk);
    bus.require = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_starve();
    logic [3:0] exp_g [5];
    logic [1:0] exp_s [5];
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
    exp_s = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
    @(negedge clk);
    set_src(0, 4'h0, 32'h0000_00AA);
    set_src(1, 4'h7, 32'h0000_00BB);
    bus.require = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if (bus.requireAC !== exp_g[k]) begin
        errors++;
        $display("FAIL starve_gnt[%0d]: got %b want %b",
                 k, bus.requireAC, exp_g[k]);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== exp_s[k]) begin
        errors++;
        $display("FAIL starve_cdb[%0d]: got v=%b s=%0d want 1/%0d",
                 k, bus.cdb_valid, bus.cdb_src, exp_s[k]);
      end
      if (k == 0) begin
        checks++;
        if (bus.cdb_label !== 4'h0 || bus.cdb_data !== 32'hAA) begin
          errors++;
          $display("FAIL label_zero: got l=%h d=%h want 0/aa",
                   bus.cdb_label, bus.cdb_data);
        end
      end
    end
    @(negedge clk);
    bus.require = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    @(negedge clk);
    bus.stall   = 1'b1;
    bus.require = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if (bus.requireAC !== 4'b0000) begin
        errors++;
        $display("FAIL stall_gnt[%0d]: got %b want 0000",
                 k, bus.requireAC);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.cdb_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_valid[%0d]: got %b want 0",
                 k, bus.cdb_valid);
      end
    end
    @(negedge clk);
    bus.stall = 1'b0;
    #1;
    checks++;
    if (bus.requireAC !== 4'b0001) begin
      errors++;
      $display("FAIL stall_release_gnt: got %b want 0001", bus.requireAC);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd0) begin
      errors++;
      $display("FAIL stall_release_cdb: got v=%b s=%0d want 1/0",
               bus.cdb_valid, bus.cdb_src);
    end
    @(negedge clk);
    bus.require = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_g [4];
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
    @(negedge clk);
    bus.require = 4'b0011;
    for (int k = 0; k < 2; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if (bus.requireAC !== 4'b0001) begin
        errors++;
        $display("FAIL rmid_pre[%0d]: got %b want 0001", k, bus.requireAC);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    RST = 1'b1;
    #1;
    checks++;
    if (bus.requireAC !== 4'b0000) begin
      errors++;
      $display("FAIL rmid_gnt: got %b want 0000", bus.requireAC);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_valid: got %b want 0", bus.cdb_valid);
    end
    @(negedge clk);
    RST = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if (bus.requireAC !== exp_g[k]) begin
        errors++;
        $display("FAIL rmid_post[%0d]: got %b want %b",
                 k, bus.requireAC, exp_g[k]);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    bus.require = 4'b0000;
    @(posedge clk); #1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    RST          = 1'b1;
    bus.require  = '0;
    bus.label_in = '0;
    bus.data_in  = '0;
    bus.stall    = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_starve();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
